hpdcache_mem_read_sched: RTL

- Shares one HPDcache memory read port between N_REQ requesters, e.g. miss handler, uncached/AMO unit and prefetcher.
- The shared port feeds the mem-to-AXI read adapter, which maps it onto the AXI AR/R channels.
- Arbitrates requests round-robin and stamps each forwarded ID with the requester index.
- Routes R beats back by ID and caps outstanding transactions per requester.

---
 rtl/hpdcache_pkg.sv | 38 +++
 rtl/hpdcache_mem_sched_rr_arb.sv | 50 +++++
 rtl/hpdcache_mem_read_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hpdcache_pkg.sv
// Shared types and sizing helpers for the HPDcache memory read scheduler.
// Default request/response structs carry the ID field the scheduler stamps.
package hpdcache_pkg;

  localparam int HPDCACHE_MEM_ID_W   = 8;
  localparam int HPDCACHE_MEM_ADDR_W = 32;
  localparam int HPDCACHE_MEM_DATA_W = 64;
  localparam int HPDCACHE_MEM_SCHED_MAX_OUTST = 8;

  typedef struct packed {
    logic [HPDCACHE_MEM_ADDR_W-1:0] mem_req_addr;
    logic [7:0]                     mem_req_len;
    logic [2:0]                     mem_req_size;
    logic [HPDCACHE_MEM_ID_W-1:0]   mem_req_id;
    logic                           mem_req_cacheable;
  } hpdcache_mem_sched_req_t;

  typedef struct packed {
    logic                           mem_resp_r_error;
    logic [HPDCACHE_MEM_ID_W-1:0]   mem_resp_r_id;
    logic [HPDCACHE_MEM_DATA_W-1:0] mem_resp_r_data;
    logic                           mem_resp_r_last;
  } hpdcache_mem_sched_resp_r_t;

  // Width of the requester index stamped into the top of the ID.
  function automatic int hpdcache_mem_sched_idx_w(input int n_req);
    return (n_req > 2) ? $clog2(n_req) : 1;
  endfunction

  // Width of an outstanding counter able to hold 0..max_outst.
  function automatic int hpdcache_mem_sched_cnt_w(input int max_outst);
    return (max_outst > 0) ? $clog2(max_outst + 1) : 1;
  endfunction

  localparam int HPDCACHE_MEM_SCHED_CNT_W =
    hpdcache_mem_sched_cnt_w(HPDCACHE_MEM_SCHED_MAX_OUTST);

endpackage

// File: rtl/hpdcache_mem_sched_rr_arb.sv
// Round-robin arbiter: the pointer names the highest-priority requester and
// moves just past the winner whenever the grant is actually consumed.
module hpdcache_mem_sched_rr_arb
  import hpdcache_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = hpdcache_mem_sched_idx_w(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] elig_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;
  logic [N_REQ-1:0] active;

  assign active = req_i & elig_i;

  // Scan from the pointer and pick the first active requester.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (!gnt_valid_o && active[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

  // Pointer moves to winner+1 (wrapping) only on a consumed grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance_i && gnt_valid_o) begin
      ptr_q <= (int'(gnt_idx_o) == N_REQ - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/hpdcache_mem_read_sched.sv
// Shares one HPDcache memory read port between N_REQ requesters.
// Requests are arbitrated round-robin into a one-entry output register with
// the requester index stamped into the top ID bits; R beats are routed back
// by that index, and in-flight reads are capped per requester.
// Optional grant statistics: define HPDCACHE_MEM_READ_SCHED_STATS_EN.
module hpdcache_mem_read_sched
  import hpdcache_pkg::*;
#(
  parameter int  N_REQ     = 2,
  parameter int  MEM_ID_W  = 8,
  parameter int  MAX_OUTST = 8,
  parameter type hpdcache_mem_req_t    = hpdcache_mem_sched_req_t,
  parameter type hpdcache_mem_resp_r_t = hpdcache_mem_sched_resp_r_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_REQ-1:0]     req_valid_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  hpdcache_mem_req_t    req_i [N_REQ],
  output logic [N_REQ-1:0]     resp_valid_o,
  input  logic [N_REQ-1:0]     resp_ready_i,
  output hpdcache_mem_resp_r_t resp_o,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output hpdcache_mem_req_t    mem_req_o,
  input  logic                 mem_resp_valid_i,
  output logic                 mem_resp_ready_o,
  input  hpdcache_mem_resp_r_t mem_resp_i,
  output logic                 err_unknown_id_o,
  output logic [31:0]          stat_grant_o [N_REQ]
);

  localparam int IDX_W = hpdcache_mem_sched_idx_w(N_REQ);
  localparam int CNT_W = hpdcache_mem_sched_cnt_w(MAX_OUTST);

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             or_loadable;
  logic             req_hs;
  logic [N_REQ-1:0] inc;
  logic [N_REQ-1:0] dec;
  logic [N_REQ-1:0] resp_sel;
  logic [IDX_W-1:0] resp_idx;
  logic             resp_idx_ok;
  logic             or_valid_q;
  logic             err_q;
  hpdcache_mem_req_t or_q;
  hpdcache_mem_req_t stamped;

  hpdcache_mem_sched_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) i_rr_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_valid_i),
    .elig_i      (elig),
    .advance_i   (req_hs),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  // The register may take a new request when empty or draining this cycle.
  assign or_loadable = !or_valid_q || mem_req_ready_i;
  assign req_hs      = or_loadable && gnt_valid;
  assign req_ready_o = or_loadable ? gnt : '0;
  assign inc         = req_hs ? gnt : '0;

  // Winner payload with its index written over the top ID bits.
  always_comb begin
    stamped = req_i[gnt_idx];
    stamped.mem_req_id[MEM_ID_W-1 -: IDX_W] = gnt_idx;
  end

  // Output register: holds steady while the port back-pressures.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      or_valid_q <= 1'b0;
      or_q       <= '0;
    end else if (req_hs) begin
      or_valid_q <= 1'b1;
      or_q       <= stamped;
    end else if (mem_req_ready_i) begin
      or_valid_q <= 1'b0;
    end
  end

  assign mem_req_valid_o = or_valid_q;
  assign mem_req_o       = or_q;

  assign resp_idx = mem_resp_i.mem_resp_r_id[MEM_ID_W-1 -: IDX_W];

  // Only a non power-of-2 requester count leaves unused index codes.
  if (N_REQ == (1 << IDX_W)) begin : g_idx_full
    assign resp_idx_ok = 1'b1;
  end else begin : g_idx_part
    assign resp_idx_ok = ({1'b0, resp_idx} < (IDX_W + 1)'(N_REQ));
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_sel
    assign resp_sel[i] = resp_idx_ok && (resp_idx == IDX_W'(i));
  end

  assign resp_valid_o     = mem_resp_valid_i ? resp_sel : '0;
  assign mem_resp_ready_o = !resp_idx_ok || |(resp_ready_i & resp_sel);
  assign dec = (mem_resp_valid_i && mem_resp_ready_o && mem_resp_i.mem_resp_r_last)
               ? resp_sel : '0;

  // Requesters send zeros in the index bits, so zeros are restored.
  always_comb begin
    resp_o = mem_resp_i;
    resp_o.mem_resp_r_id[MEM_ID_W-1 -: IDX_W] = '0;
  end

  // Unknown-index beats are swallowed and latch a sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (mem_resp_valid_i && !resp_idx_ok) begin
      err_q <= 1'b1;
    end
  end

  assign err_unknown_id_o = err_q;

  for (genvar i = 0; i < N_REQ; i++) begin : g_outst
    logic [CNT_W-1:0] outst_q;

    assign elig[i] = req_valid_i[i] && (outst_q < CNT_W'(MAX_OUTST));

    // Counted on entry to the output register, released on the last beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        outst_q <= '0;
      end else if (inc[i] && !dec[i]) begin
        outst_q <= outst_q + 1'b1;
      end else if (dec[i] && !inc[i]) begin
        outst_q <= outst_q - 1'b1;
      end
    end

    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dec[i] && !inc[i] && outst_q == '0));
  end

`ifdef HPDCACHE_MEM_READ_SCHED_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    logic [31:0] cnt_q;

    // Saturating grant counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else if (inc[i] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign stat_grant_o[i] = cnt_q;
  end
`else
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat_off
    assign stat_grant_o[i] = '0;
  end
`endif

endmodule
